// File: rtl/lab02_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab02_pkg
//  Description : Shared definitions for the lab02 function evaluator family:
//                scan FSM state encoding and the power-up truth table.
//  Revision    : 1.0  initial release
// ============================================================================
package lab02_pkg;

    // Scan FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // f1 = ~b~c | ~ab | ac, bit k holds f1 for {a,b,c} = k
    localparam logic [7:0] DEFAULT_TT = 8'hBD;

endpackage : lab02_pkg
`default_nettype wire

// File: rtl/minterm_enumerator.sv
`default_nettype none
// ============================================================================
//  Module      : minterm_enumerator
//  Description : Scans every input combination of a latched truth table and
//                emits, one per valid/ready handshake, each index whose
//                output equals the latched target; then pulses done with the
//                number of matches emitted.
//  Revision    : 1.0  initial release
// ============================================================================
module minterm_enumerator
    import lab02_pkg::*;
#(
    parameter int                  N_IN       = 3,
    parameter logic [2**N_IN-1:0]  DEFAULT_TT = lab02_pkg::DEFAULT_TT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   tt_in,
    input  logic                 target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_IN-1:0]      out_idx,
    output logic                 busy,
    output logic                 done,
    output logic [N_IN:0]        count
);

    localparam logic [N_IN-1:0] C_LAST_IDX  = '1;
    localparam logic [N_IN:0]   C_COUNT_ONE = {{N_IN{1'b0}}, 1'b1};

    state_t              r_state;
    logic [2**N_IN-1:0]  r_tt;
    logic                r_target;
    logic [N_IN-1:0]     r_idx;

    // Scan FSM with index counter, match counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tt      <= DEFAULT_TT;
            r_target  <= 1'b0;
            r_idx     <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_tt     <= tt_in;
                        r_target <= target;
                        r_idx    <= '0;
                        count    <= '0;
                        busy     <= 1'b1;
                        r_state  <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (r_tt[r_idx] == r_target) begin
                        out_idx   <= r_idx;
                        out_valid <= 1'b1;
                        r_state   <= ST_EMIT;
                    end else if (r_idx == C_LAST_IDX) begin
                        // Last index is a terminator, never incremented past
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                ST_EMIT: begin
                    // out_valid/out_idx stay put until the consumer takes them
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        count     <= count + C_COUNT_ONE;
                        if (r_idx == C_LAST_IDX) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_SCAN;
                        end
                    end
                end

                ST_DONE: begin
                    // start is deliberately not sampled here
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : minterm_enumerator
`default_nettype wire

// File: tb/tb_minterm_enumerator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_minterm_enumerator
//  Description : Directed self-checking bench for minterm_enumerator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_minterm_enumerator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] tt_in;
    logic       target;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       busy;
    logic       done;
    logic [3:0] count;

    int checks;
    int errors;

    // Results gathered by collect()
    int         got[$];
    int         done_pulses;
    int         first_done;
    logic [3:0] cnt_at_done;
    logic       busy_first;
    logic       busy_after;

    minterm_enumerator #(
        .N_IN       (3),
        .DEFAULT_TT (8'hBD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tt_in     (tt_in),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge; returns at the negedge after acceptance
    task automatic do_start(input logic [7:0] tt, input logic tgt);
        @(negedge clk);
        tt_in  = tt;
        target = tgt;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Observe a fixed window, one sample per negedge (sample n lies between
    // the n-th and (n+1)-th edge after start was accepted)
    task automatic collect(input int ncyc, input int inject_at);
        got.delete();
        done_pulses = 0;
        first_done  = -1;
        cnt_at_done = 4'hx;
        busy_first  = busy;
        busy_after  = 1'bx;
        for (int n = 0; n < ncyc; n++) begin
            if (out_valid && out_ready) got.push_back(int'(out_idx));
            if (done) begin
                done_pulses++;
                if (first_done < 0) begin
                    first_done  = n;
                    cnt_at_done = count;
                end
            end
            if (first_done >= 0 && n == first_done + 1) busy_after = busy;
            if (n == inject_at) begin
                start  = 1'b1;
                tt_in  = 8'h00;
                target = 1'b0;
            end else if (n == inject_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; tt_in = 8'h00; target = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_idx, busy, done, count} !== 10'd0) begin
            errors++;
            $display("FAIL reset_state got valid=%b idx=%0d busy=%b done=%b count=%0d want all 0",
                     out_valid, out_idx, busy, done, count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_emit;
        out_ready = 1'b0;
        do_start(8'hBD, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd0) begin
            errors++;
            $display("FAIL pre_reset_emit got valid=%b idx=%0d want valid=1 idx=0", out_valid, out_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_idx, busy, done, count} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset_mid_emit got valid=%b idx=%0d busy=%b done=%b count=%0d want all 0",
                     out_valid, out_idx, busy, done, count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        collect(6, -1);
        checks++;
        if (done_pulses !== 0) begin
            errors++;
            $display("FAIL reset_no_done got %0d done pulses want 0", done_pulses);
        end
    endtask

    task automatic test_match_ones;
        int exp[6] = '{0, 2, 3, 4, 5, 7};
        out_ready = 1'b1;
        do_start(8'hBD, 1'b1);
        collect(30, -1);
        checks++;
        if (busy_first !== 1'b1) begin
            errors++;
            $display("FAIL ones_busy got %b want 1", busy_first);
        end
        checks++;
        if (got.size() !== 6) begin
            errors++;
            $display("FAIL ones_len got %0d want 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL ones_idx[%0d] got %0d want %0d", i, got[i], exp[i]);
                end
            end
        end
        checks++;
        if (done_pulses !== 1 || cnt_at_done !== 4'd6) begin
            errors++;
            $display("FAIL ones_done got pulses=%0d count=%0d want 1 and 6", done_pulses, cnt_at_done);
        end
        checks++;
        if (count !== 4'd6) begin
            errors++;
            $display("FAIL ones_count_hold got %0d want 6", count);
        end
    endtask

    task automatic test_match_zeros;
        out_ready = 1'b1;
        do_start(8'hBD, 1'b0);
        collect(20, -1);
        checks++;
        if (got.size() !== 2 || got[0] !== 1 || got[1] !== 6) begin
            errors++;
            $display("FAIL zeros_seq got len=%0d first=%0d last=%0d want 1,6",
                     got.size(), (got.size() > 0) ? got[0] : -1, (got.size() > 1) ? got[1] : -1);
        end
        checks++;
        if (done_pulses !== 1 || cnt_at_done !== 4'd2) begin
            errors++;
            $display("FAIL zeros_done got pulses=%0d count=%0d want 1 and 2", done_pulses, cnt_at_done);
        end
        checks++;
        if (busy_after !== 1'b0) begin
            errors++;
            $display("FAIL zeros_busy_after_done got %b want 0", busy_after);
        end
    endtask

    task automatic test_empty;
        out_ready = 1'b1;
        do_start(8'h00, 1'b1);
        collect(14, -1);
        checks++;
        if (got.size() !== 0) begin
            errors++;
            $display("FAIL empty_no_valid got %0d emits want 0", got.size());
        end
        checks++;
        if (done_pulses !== 1 || first_done !== 8) begin
            errors++;
            $display("FAIL empty_done_timing got pulses=%0d at=%0d want 1 at 8", done_pulses, first_done);
        end
        checks++;
        if (cnt_at_done !== 4'd0) begin
            errors++;
            $display("FAIL empty_count got %0d want 0", cnt_at_done);
        end
    endtask

    task automatic test_full_backpressure;
        out_ready = 1'b0;
        do_start(8'hFF, 1'b1);
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'd0) begin
                errors++;
                $display("FAIL stall[%0d] got valid=%b idx=%0d want valid=1 idx=0", s, out_valid, out_idx);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        collect(30, -1);
        checks++;
        if (got.size() !== 8) begin
            errors++;
            $display("FAIL full_len got %0d want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== i) begin
                    errors++;
                    $display("FAIL full_idx[%0d] got %0d want %0d", i, got[i], i);
                end
            end
        end
        checks++;
        if (done_pulses !== 1 || cnt_at_done !== 4'b1000) begin
            errors++;
            $display("FAIL full_count got pulses=%0d count=%0d want 1 and 8", done_pulses, cnt_at_done);
        end
    endtask

    task automatic test_start_ignored;
        out_ready = 1'b1;
        do_start(8'hBD, 1'b1);
        collect(30, 2);
        checks++;
        if (got.size() !== 6 || got[0] !== 0 || got[5] !== 7) begin
            errors++;
            $display("FAIL ignored_start_seq got len=%0d want 6 (0..7)", got.size());
        end
        checks++;
        if (done_pulses !== 1 || cnt_at_done !== 4'd6) begin
            errors++;
            $display("FAIL ignored_start_done got pulses=%0d count=%0d want 1 and 6", done_pulses, cnt_at_done);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_mid_emit();
        test_match_ones();
        test_match_zeros();
        test_empty();
        test_full_backpressure();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_minterm_enumerator
`default_nettype wire
